comp_search: RTL and testbench
==============================

# comp_search

Successive-approximation search controller that sits on the `a` side of a `COMP` instance. It drives the comparator's probe operand and consumes the `gt`/`lt`/`eq` flags. From those flags it recovers the unsigned value on the comparator's `b` input, MSB first, at one compare per clock, and exits early on equality. It is the sequential consumer of the comparator flag interface and is used wherever a datapath must digitise or locate an unknown operand through a compare-only path.

## Interface
- `DATAWIDTH`, default 64: width of the probe, the searched value and the result.
- `Clk` input 1: the single clock; all state changes on its rising edge.
- `Rst` input 1: asynchronous, active-low reset.
- `start` input 1: request a new search. Sampled only in IDLE, or in DONE together with `ack`.
- `busy` output 1: high while in SEARCH.
- `a` output DATAWIDTH: probe to the comparator's `a` input.
- `gt`, `lt`, `eq` inputs 1 each: comparator flags for the current `a` versus the unknown `b`.
- `result` output DATAWIDTH: recovered value, held while `valid` is high.
- `valid` output 1: result available; held until acknowledged.
- `ack` input 1: consumer accepts `result`. Sampled only while `valid` is high.
- `err` output 1: flag fault detected. Qualified by `valid`.
- `steps` output $clog2(DATAWIDTH)+1: number of compares used in the last search.

## Operation
- States: IDLE, SEARCH, DONE.
- IDLE
  - On `start`: clear `acc`, set `bit_idx` to DATAWIDTH-1, clear `steps`, go to SEARCH.
- SEARCH
  - `a` equals `acc` with bit `bit_idx` set (the trial value).
  - Flags are sampled every cycle and `steps` increments every cycle.
  - `lt`: set the trial bit in `acc`.
  - `gt`: leave `acc` unchanged.
  - `eq`: load `acc` with the trial value and go to DONE (early exit).
  - If none of the above exited and `bit_idx` is 0, go to DONE. Otherwise decrement `bit_idx`.
- Flag fault: if the flags are not exactly one-hot, go to DONE with `err` set and `result` equal to `acc` before this cycle's update.
- DONE
  - `valid` is 1 and `result` equals `acc`.
  - `ack` without `start`: go to IDLE and drop `valid`.
  - `ack` with `start` in the same cycle: restart directly into SEARCH.
- `start` in SEARCH, or in DONE without `ack`, is ignored (it is not queued).
- `a` is 0 outside SEARCH.
- Flags are ignored outside SEARCH.
- Arithmetic is unsigned, and the final result equals `b` for any constant `b`. For `b` = 0 every trial returns `gt`, so the search runs the full DATAWIDTH steps and the result is 0.

## Timing
- Reset values: state IDLE; `busy` 0, `valid` 0, `err` 0, `a` 0, `result` 0, `steps` 0. Reset takes effect immediately, including in mid-search, and discards the search in progress.
- `start` sampled at edge 0 gives `busy` = 1 and the first probe on `a` from cycle 1.
- `a` depends only on registers. The comparator path (register → COMP → flags → register) must close in one cycle.
- Latency from the `start` edge to `valid` high is `steps`+1 cycles, where `steps` ranges from 1 to DATAWIDTH.
- `busy` falls in the same cycle that `valid` rises.
- `valid`, `result`, `err` and `steps` are stable from DONE entry until the cycle after `ack`.
- `b` must be held constant while `busy` is high. If `b` changes mid-search, the result is undefined but `err` is not required to flag it.

## Structure
- Shared defines file holds the state encodings (IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2) and the `steps` width macro. The file is reused by other flag-consuming controllers.
- No sub-module inside the block; the trial value and one-hot check are local logic.
- The bench, and any top that uses the block, instantiate `COMP` next to it: `a` ← `a`, and the flags go back to the controller.

## Test plan (DATAWIDTH = 8, real `COMP` in loop)
- `b` = 0x80, pulse `start` → `eq` on the first compare; `valid` 2 cycles after `start`; `result` 0x80; `steps` 1; `err` 0.
- `b` = 0x00 → probes 0x80, 0x40, …, 0x01 all `gt`; `result` 0x00; `steps` 8; `valid` 9 cycles after `start`.
- `b` = 0x55 → probe sequence 0x80, 0x40, 0x60, 0x50, 0x58, 0x54, 0x56, 0x55 (`eq`); `result` 0x55; `steps` 8.
- `b` = 0xFF, hold `ack` low 5 cycles → `valid` and `result` 0xFF held throughout. Then assert `ack` and `start` together → new search starts the next cycle, with `valid` low.
- Force `gt` = `lt` = 1 on the third compare → DONE with `err` 1 and `steps` 3. A `start` pulse in mid-search is ignored.
- Assert `Rst` low in mid-search → outputs go to reset values immediately. After release, a new `start` completes correctly for `b` = 0x3C.

Source files
------------

// File: rtl/comp_search_pkg.sv
// Shared definitions for controllers that consume COMP gt/lt/eq flags.
// Holds the controller state encoding and the compare-count width helper.
package comp_search_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Width of a counter that must hold 0..dw inclusive.
    function automatic int steps_w(input int dw);
        return $clog2(dw) + 1;
    endfunction

    // Width of a bit index into a dw-wide word (at least one bit).
    function automatic int idx_w(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/comp_search_comp.sv
// Unsigned magnitude comparator producing one-hot gt/lt/eq flags.
// Purely combinational so the probe-to-flag loop closes in one cycle.
module COMP #(
    parameter int DATAWIDTH = 64
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 gt,
    output logic                 lt,
    output logic                 eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/comp_search.sv
// Successive-approximation search controller recovering the unknown COMP
// operand MSB first, one compare per clock, with early exit on equality.
module comp_search
    import comp_search_pkg::*;
#(
    parameter int DATAWIDTH = 64
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic                            start,
    output logic                            busy,
    output logic [DATAWIDTH-1:0]            a,
    input  logic                            gt,
    input  logic                            lt,
    input  logic                            eq,
    output logic [DATAWIDTH-1:0]            result,
    output logic                            valid,
    input  logic                            ack,
    output logic                            err,
    output logic [steps_w(DATAWIDTH)-1:0]   steps
);

    localparam int SW = steps_w(DATAWIDTH);
    localparam int IW = idx_w(DATAWIDTH);

    state_e                 state_q, state_d;
    logic [DATAWIDTH-1:0]   acc_q, acc_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [SW-1:0]          steps_q, steps_d;
    logic                   err_q, err_d;

    logic [DATAWIDTH-1:0]   one_w;
    logic [DATAWIDTH-1:0]   trial;
    logic                   flags_ok;

    assign one_w    = DATAWIDTH'(1);
    assign trial    = acc_q | (one_w << idx_q);
    assign flags_ok = $onehot({gt, lt, eq});

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            steps_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            steps_q <= steps_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        steps_d = steps_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEARCH;
                    acc_d   = '0;
                    idx_d   = IW'(DATAWIDTH - 1);
                    steps_d = '0;
                    err_d   = 1'b0;
                end
            end
            SEARCH: begin
                steps_d = steps_q + SW'(1);
                // A faulty flag set freezes acc at its pre-compare value.
                if (!flags_ok) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (eq) begin
                    acc_d   = trial;
                    state_d = DONE;
                end else begin
                    if (lt) begin
                        acc_d = trial;
                    end
                    if (idx_q == '0) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end
            end
            DONE: begin
                if (ack) begin
                    if (start) begin
                        state_d = SEARCH;
                        acc_d   = '0;
                        idx_d   = IW'(DATAWIDTH - 1);
                        steps_d = '0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q == SEARCH);
    assign valid  = (state_q == DONE);
    assign a      = busy ? trial : '0;
    assign result = valid ? acc_q : '0;
    assign err    = valid & err_q;
    assign steps  = steps_q;

endmodule

// File: tb/tb_comp_search.sv
// Directed scoreboard bench for comp_search with a real COMP in the loop.
// Expected results are queued at start and popped when valid rises.
module tb_comp_search;

    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] r;
        int            s;
        logic          e;
    } exp_t;

    logic          Clk;
    logic          Rst;
    logic          start;
    logic          busy;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          c_gt, c_lt, c_eq;
    logic          gt, lt, eq;
    logic [DW-1:0] result;
    logic          valid;
    logic          ack;
    logic          err;
    logic [3:0]    steps;
    logic          fault;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t          sbq[$];
    logic [DW-1:0] pq[$];

    comp_search #(.DATAWIDTH(DW)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .start  (start),
        .busy   (busy),
        .a      (a),
        .gt     (gt),
        .lt     (lt),
        .eq     (eq),
        .result (result),
        .valid  (valid),
        .ack    (ack),
        .err    (err),
        .steps  (steps)
    );

    COMP #(.DATAWIDTH(DW)) u_comp (
        .a  (a),
        .b  (b),
        .gt (c_gt),
        .lt (c_lt),
        .eq (c_eq)
    );

    // Fault injection drives gt and lt high together.
    assign gt = fault ? 1'b1 : c_gt;
    assign lt = fault ? 1'b1 : c_lt;
    assign eq = fault ? 1'b0 : c_eq;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Compares to reach b: MSB-first search hits eq at b's lowest set bit.
    function automatic int model_steps(input logic [DW-1:0] bv);
        int s;
        s = DW;
        for (int i = DW - 1; i >= 0; i--) begin
            if (bv[i]) s = DW - i;
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic launch(input logic [DW-1:0] bv, input exp_t e);
        b     = bv;
        sbq.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic start_search(input logic [DW-1:0] bv);
        exp_t e;
        e.r = bv;
        e.s = model_steps(bv);
        e.e = 1'b0;
        launch(bv, e);
    endtask

    task automatic wait_done(input string tag, input int n0);
        int   n;
        exp_t e;
        n = n0;
        while (!valid && n < 40) begin
            if (pq.size() > 0) chk({tag, "_probe"}, a, pq.pop_front());
            tick();
            n++;
        end
        chk({tag, "_timeout"}, valid, 1);
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_result"}, result, e.r);
            chk({tag, "_steps"}, steps, e.s);
            chk({tag, "_err"}, err, e.e);
            chk({tag, "_busy"}, busy, 0);
            chk({tag, "_latency"}, n + 1, e.s + 1);
        end
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk({tag, "_valid_drop"}, valid, 0);
        chk({tag, "_idle_a"}, a, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_a"}, a, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_steps"}, steps, 0);
    endtask

    initial begin
        exp_t fe;
        Rst   = 1'b0;
        start = 1'b0;
        ack   = 1'b0;
        fault = 1'b0;
        b     = '0;
        #12;
        chk_reset("rst");
        Rst = 1'b1;
        tick();

        start_search(8'h80);
        wait_done("b80", 0);
        do_ack("b80");

        for (int i = DW - 1; i >= 0; i--) pq.push_back(DW'(1) << i);
        start_search(8'h00);
        wait_done("b00", 0);
        do_ack("b00");

        pq.push_back(8'h80); pq.push_back(8'h40);
        pq.push_back(8'h60); pq.push_back(8'h50);
        pq.push_back(8'h58); pq.push_back(8'h54);
        pq.push_back(8'h56); pq.push_back(8'h55);
        start_search(8'h55);
        wait_done("b55", 0);
        chk("b55_probes_used", pq.size(), 0);
        do_ack("b55");

        start_search(8'hFF);
        wait_done("bff", 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bff_hold_valid", valid, 1);
            chk("bff_hold_result", result, 8'hFF);
        end
        fe.r = 8'hA7;
        fe.s = model_steps(8'hA7);
        fe.e = 1'b0;
        b    = 8'hA7;
        sbq.push_back(fe);
        ack   = 1'b1;
        start = 1'b1;
        tick();
        ack   = 1'b0;
        start = 1'b0;
        chk("restart_valid", valid, 0);
        chk("restart_busy", busy, 1);
        chk("restart_probe", a, 8'h80);
        wait_done("ba7", 0);
        do_ack("ba7");

        fe.r = 8'h40;
        fe.s = 3;
        fe.e = 1'b1;
        launch(8'h55, fe);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        fault = 1'b1;
        wait_done("flt", 2);
        fault = 1'b0;
        do_ack("flt");

        b     = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_rst_busy", busy, 1);
        Rst = 1'b0;
        #1;
        chk_reset("midrst");
        #1;
        Rst = 1'b1;
        tick();
        start_search(8'h3C);
        wait_done("b3c", 0);
        do_ack("b3c");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
